// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared state encoding and row/timer sizing for the truth-table sweeper
package truth_table_pkg;
  localparam int ROWS = 8;
  localparam int ROW_W = 3;
  localparam int TIMER_W = 8;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter whose expired flag marks the last hold cycle (count==1)
module settle_timer
  import truth_table_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  end
  assign expired = cnt == W'(1);
endmodule

// File: rtl/truth_table_sweep.sv
// truth_table_sweep: drives in1..in3 through rows 0..7, samples dut_out into meas_table, flags match vs EXPECTED
module truth_table_sweep
  import truth_table_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] EXPECTED      = 8'hBB
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] meas_table,
  output logic       match
);
  state_t state, nxt;
  logic [ROW_W-1:0] row, nxt_row;
  logic [7:0] smp;
  logic load, dec, expired, clr;
  settle_timer #(.W(TIMER_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .dec(dec),
    .load_val(TIMER_W'(SETTLE_CYCLES)),
    .expired(expired)
  );
  always_comb begin
    nxt = state;
    load = 1'b0;
    dec = 1'b0;
    case (state)
      IDLE: begin
        nxt = start ? DRIVE : IDLE;
        load = start;
      end
      DRIVE: begin
        nxt = abort ? IDLE : expired ? SAMPLE : DRIVE;
        dec = !abort && !expired;
      end
      SAMPLE: begin
        nxt = abort ? IDLE : (row == ROW_W'(ROWS - 1)) ? FINISH : DRIVE;
        load = !abort && (row != ROW_W'(ROWS - 1));
      end
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    smp = meas_table;
    smp[ROW_W'(ROWS - 1) - row] = dut_out;
  end
  assign nxt_row = (nxt == DRIVE || nxt == SAMPLE) ? ((state == SAMPLE) ? row + 1'b1 : row) : '0;
  assign clr = (state == IDLE && start) || ((state == DRIVE || state == SAMPLE) && abort);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      {in1, in2, in3} <= 3'b000;
      busy <= 1'b0;
      done <= 1'b0;
      meas_table <= 8'h00;
      match <= 1'b0;
    end else begin
      state <= nxt;
      row <= nxt_row;
      {in1, in2, in3} <= nxt_row;
      busy <= nxt != IDLE;
      done <= nxt == FINISH;
      if (clr) begin
        meas_table <= 8'h00;
        match <= 1'b0;
      end else if (state == SAMPLE) begin
        meas_table <= smp;
        match <= (nxt == FINISH) && (smp == EXPECTED);
      end
    end
  end
endmodule

// File: tb/tb_truth_table_sweep.sv
// tb_truth_table_sweep: vector table, random sweeps and hand sequences against a gate model
module tb_truth_table_sweep;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [7:0] gate_a = 8'h00, gate_b = 8'h00;
  logic dut_out_a, dut_out_b;
  logic in1_a, in2_a, in3_a, busy_a, done_a, match_a;
  logic in1_b, in2_b, in3_b, busy_b, done_b, match_b;
  logic [7:0] table_a, table_b;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  assign dut_out_a = gate_resp(gate_a, {in1_a, in2_a, in3_a});
  assign dut_out_b = gate_resp(gate_b, {in1_b, in2_b, in3_b});
  truth_table_sweep u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .dut_out(dut_out_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a), .busy(busy_a), .done(done_a),
    .meas_table(table_a), .match(match_a)
  );
  truth_table_sweep #(.SETTLE_CYCLES(1), .EXPECTED(8'h96)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .dut_out(dut_out_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .busy(busy_b), .done(done_b),
    .meas_table(table_b), .match(match_b)
  );
  typedef struct {
    bit sel;
    logic [7:0] gate;
    logic [7:0] tbl;
    bit m;
    int restart;
    int abort_at;
  } vec_t;
  vec_t vecs[9];
  function automatic logic gate_resp(input logic [7:0] g, input logic [2:0] r);
    return g[3'd7 - r];
  endfunction
  function automatic logic [7:0] model_table(input logic [7:0] g);
    logic [7:0] t;
    for (int r = 0; r < 8; r++) t[7 - r] = gate_resp(g, 3'(r));
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drv(input bit sel, input logic st, input logic ab);
    if (sel) begin start_b = st; abort_b = ab; end
    else begin start_a = st; abort_a = ab; end
  endtask
  task automatic run(input vec_t v);
    int s, d, done_at, done_n, busy_err, in_err, row;
    logic bz, dn;
    logic [2:0] iv;
    logic [7:0] tbl_done;
    logic m_done;
    s = v.sel ? 1 : 4;
    d = 8 * (s + 1) + 1;
    done_at = -1; done_n = 0; busy_err = 0; in_err = 0;
    tbl_done = 8'hxx; m_done = 1'bx;
    @(negedge clk);
    if (v.sel) gate_b = v.gate; else gate_a = v.gate;
    drv(v.sel, 1'b1, v.abort_at == 0);
    for (int k = 1; k <= d + 3; k++) begin
      @(negedge clk);
      bz = v.sel ? busy_b : busy_a;
      dn = v.sel ? done_b : done_a;
      iv = v.sel ? {in1_b, in2_b, in3_b} : {in1_a, in2_a, in3_a};
      row = (k >= 1 && k <= d - 1) ? (k - 1) / (s + 1) : 0;
      if (bz !== (k <= d)) busy_err++;
      if (iv !== 3'(row)) in_err++;
      if (dn === 1'b1) begin
        done_n++;
        if (done_at < 0) begin
          done_at = k;
          tbl_done = v.sel ? table_b : table_a;
          m_done = v.sel ? match_b : match_a;
        end
      end
      drv(v.sel, k == v.restart, k == v.abort_at);
    end
    drv(v.sel, 1'b0, 1'b0);
    chk("done_cycle", done_at, d);
    chk("done_pulses", done_n, 1);
    chk("busy_profile_errs", busy_err, 0);
    chk("input_row_errs", in_err, 0);
    chk("table_at_done", tbl_done, v.tbl);
    chk("match_at_done", m_done, v.m);
    chk("table_held", v.sel ? table_b : table_a, v.tbl);
    chk("match_held", v.sel ? match_b : match_a, v.m);
  endtask
  initial begin
    vec_t rv;
    int done_at;
    vecs[0] = '{0, 8'hBB, 8'hBB, 1, 0, -1};
    vecs[1] = '{0, 8'h00, 8'h00, 0, 0, -1};
    vecs[2] = '{0, 8'hBB, 8'hBB, 1, 10, -1};
    vecs[3] = '{1, 8'hBB, 8'hBB, 0, 0, -1};
    vecs[4] = '{1, 8'h96, 8'h96, 1, 0, -1};
    vecs[5] = '{0, 8'hFF, 8'hFF, 0, 0, 0};
    vecs[6] = '{0, 8'hBB, 8'hBB, 1, 0, 41};
    vecs[7] = '{1, 8'h01, 8'h01, 0, 5, -1};
    vecs[8] = '{0, 8'h5A, 8'h5A, 0, 0, -1};
    repeat (3) @(negedge clk);
    chk("reset_a", {in1_a, in2_a, in3_a, busy_a, done_a, table_a, match_a}, 0);
    chk("reset_b", {in1_b, in2_b, in3_b, busy_b, done_b, table_b, match_b}, 0);
    rst = 1'b0;
    foreach (vecs[i]) run(vecs[i]);
    for (int i = 0; i < 10; i++) begin
      rv.sel = 1'($urandom_range(0, 1));
      rv.gate = 8'($urandom);
      rv.tbl = model_table(rv.gate);
      rv.m = rv.tbl == (rv.sel ? 8'h96 : 8'hBB);
      rv.restart = $urandom_range(0, 30);
      rv.abort_at = -1;
      run(rv);
    end
    @(negedge clk);
    gate_a = 8'hBB;
    start_a = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (k == 17) begin
        chk("abort_pre_row", {in1_a, in2_a, in3_a}, 3'd3);
        chk("abort_pre_table", table_a, 8'hA0);
        abort_a = 1'b1;
      end
    end
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_idle", {busy_a, in1_a, in2_a, in3_a, table_a, match_a, done_a}, 0);
    done_at = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done_a || busy_a) done_at++;
    end
    chk("abort_no_done", done_at, 0);
    run(vecs[0]);
    @(negedge clk);
    gate_a = 8'hBB;
    start_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start_a = k == 20;
      rst = k == 20;
    end
    @(negedge clk);
    chk("rst_mid_sweep", {in1_a, in2_a, in3_a, busy_a, done_a, table_a, match_a}, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_busy", busy_a, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_start", busy_a, 1);
    start_a = 1'b0;
    done_at = -1;
    for (int k = 2; k <= 60 && done_at < 0; k++) begin
      @(negedge clk);
      if (done_a) done_at = k;
    end
    chk("rst_restart_done", done_at, 41);
    chk("rst_restart_table", table_a, 8'hBB);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
